// File: rtl/sar_conv_ctrl.sv
// Conversion sequencer for a 10-bit SAR: drives CLKS, synchronises CLKC, guards CONVERT
// with a watchdog and hands each captured result to a valid/ready consumer.
module sar_conv_ctrl #(
  parameter int NBITS          = 10,
  parameter int SAMPLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont_mode,
  output logic             sar_clks,
  input  logic             sar_clkc,
  input  logic [NBITS-1:0] sar_d,
  output logic [NBITS-1:0] res_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic             timeout_err,
  output logic             overrun_err,
  input  logic             clear_err,
  output logic [15:0]      conv_cnt
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SAMPLE  = 2'd1;
  localparam logic [1:0] ST_CONVERT = 2'd2;
  localparam logic [1:0] ST_CAPTURE = 2'd3;

  localparam logic [7:0]  SAMPLE_LOAD = 8'(SAMPLE_CYCLES);
  localparam logic [15:0] WD_LIMIT    = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]       r_state;
  logic [7:0]       r_sample_cnt;
  logic [15:0]      r_wd_cnt;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_sar_clks;
  logic             r_busy;
  logic [NBITS-1:0] r_res_data;
  logic             r_res_valid;
  logic             r_timeout_err;
  logic             r_overrun_err;
  logic [15:0]      r_conv_cnt;

  logic [1:0]  w_state_next;
  logic [7:0]  w_sample_cnt_next;
  logic [15:0] w_wd_cnt_next;
  logic        w_done_s;
  logic        w_set_timeout;
  logic        w_capture;
  logic        w_drop;

  // CLKC is active-low "done"; the flops idle high so a fresh reset never looks complete.
  assign w_done_s = ~r_sync2;

  always_comb begin
    w_state_next      = r_state;
    w_sample_cnt_next = r_sample_cnt;
    w_wd_cnt_next     = r_wd_cnt;
    w_set_timeout     = 1'b0;
    w_capture         = 1'b0;
    w_drop            = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start || cont_mode) begin
          w_state_next      = ST_SAMPLE;
          w_sample_cnt_next = SAMPLE_LOAD;
        end
      end
      ST_SAMPLE: begin
        if (r_sample_cnt == 8'd1) begin
          w_state_next  = ST_CONVERT;
          w_wd_cnt_next = 16'd0;
        end else begin
          w_sample_cnt_next = r_sample_cnt - 8'd1;
        end
      end
      ST_CONVERT: begin
        // Completion wins over the watchdog when both land in the same cycle.
        if (w_done_s) begin
          w_state_next = ST_CAPTURE;
        end else if (r_wd_cnt == WD_LIMIT) begin
          w_set_timeout = 1'b1;
          w_state_next  = ST_IDLE;
        end else begin
          w_wd_cnt_next = r_wd_cnt + 16'd1;
        end
      end
      ST_CAPTURE: begin
        if (!r_res_valid || res_ready) begin
          w_capture = 1'b1;
        end else begin
          w_drop = 1'b1;
        end
        w_sample_cnt_next = SAMPLE_LOAD;
        w_state_next      = cont_mode ? ST_SAMPLE : ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_sample_cnt  <= 8'd0;
      r_wd_cnt      <= 16'd0;
      r_sync1       <= 1'b1;
      r_sync2       <= 1'b1;
      r_sar_clks    <= 1'b1;
      r_busy        <= 1'b0;
      r_res_data    <= '0;
      r_res_valid   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_overrun_err <= 1'b0;
      r_conv_cnt    <= 16'd0;
    end else begin
      r_sync1      <= sar_clkc;
      r_sync2      <= r_sync1;
      r_state      <= w_state_next;
      r_sample_cnt <= w_sample_cnt_next;
      r_wd_cnt     <= w_wd_cnt_next;
      // CLKS stays low through CAPTURE so D is still held while it is sampled.
      r_sar_clks   <= (w_state_next == ST_IDLE) || (w_state_next == ST_SAMPLE);
      r_busy       <= (w_state_next != ST_IDLE);

      if (w_capture) begin
        r_res_data  <= sar_d;
        r_res_valid <= 1'b1;
        r_conv_cnt  <= r_conv_cnt + 16'd1;
      end else if (r_res_valid && res_ready) begin
        r_res_valid <= 1'b0;
      end

      if (w_set_timeout) begin
        r_timeout_err <= 1'b1;
      end else if (clear_err) begin
        r_timeout_err <= 1'b0;
      end

      if (w_drop) begin
        r_overrun_err <= 1'b1;
      end else if (clear_err) begin
        r_overrun_err <= 1'b0;
      end
    end
  end

  assign sar_clks    = r_sar_clks;
  assign busy        = r_busy;
  assign res_data    = r_res_data;
  assign res_valid   = r_res_valid;
  assign timeout_err = r_timeout_err;
  assign overrun_err = r_overrun_err;
  assign conv_cnt    = r_conv_cnt;

endmodule

// File: tb/tb_sar_conv_ctrl.sv
// Directed bench for sar_conv_ctrl with a simple SAR model answering CLKS with CLKC/D.
module tb_sar_conv_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cont_mode = 1'b0;
  logic       sar_clkc = 1'b1;
  logic [9:0] sar_d = 10'd0;
  logic       res_ready = 1'b0;
  logic       clear_err = 1'b0;
  logic       sar_clks;
  logic [9:0] res_data;
  logic       res_valid;
  logic       busy;
  logic       timeout_err;
  logic       overrun_err;
  logic [15:0] conv_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // SAR model: after CLKS falls, pull CLKC low model_delay cycles later with the next value.
  logic       model_en    = 1'b1;
  int         model_delay = 20;
  logic [9:0] model_base  = 10'd0;
  logic [9:0] model_idx   = 10'd0;
  int         low_cnt     = 0;

  sar_conv_ctrl #(
    .NBITS(10),
    .SAMPLE_CYCLES(4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .cont_mode(cont_mode),
    .sar_clks(sar_clks),
    .sar_clkc(sar_clkc),
    .sar_d(sar_d),
    .res_data(res_data),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .busy(busy),
    .timeout_err(timeout_err),
    .overrun_err(overrun_err),
    .clear_err(clear_err),
    .conv_cnt(conv_cnt)
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #2;
    if (sar_clks === 1'b1) begin
      sar_clkc = 1'b1;
      low_cnt  = 0;
    end else if (model_en) begin
      low_cnt++;
      if (low_cnt == model_delay) begin
        sar_clkc  = 1'b0;
        sar_d     = model_base + model_idx;
        model_idx = model_idx + 10'd1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
    $fatal(1, "global timeout");
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_clks(input logic lvl, input string tag);
    int n = 0;
    while (sar_clks !== lvl && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (sar_clks !== lvl) begin
      n_checks++;
      $display("FAIL %s: sar_clks stuck at %b, required %b", tag, sar_clks, lvl);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      n_checks++;
      $display("FAIL %s: busy stuck at %b, required 0", tag, busy);
    end
  endtask

  task automatic wait_clkc_low(input string tag);
    int n = 0;
    while (sar_clkc !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (sar_clkc !== 1'b0) begin
      n_checks++;
      $display("FAIL %s: sar_clkc never went low, required 0", tag);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({sar_clks, busy, res_valid, timeout_err, overrun_err} !== 5'b10000)
      $display("FAIL reset_flags: got %b, required 10000", {sar_clks, busy, res_valid, timeout_err, overrun_err});
    else n_pass++;
    n_checks++;
    if (res_data !== 10'h000) $display("FAIL reset_data: got %h, required 000", res_data);
    else n_pass++;
    n_checks++;
    if (conv_cnt !== 16'h0000) $display("FAIL reset_cnt: got %h, required 0000", conv_cnt);
    else n_pass++;
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single_shot();
    int hi  = 0;
    int lat = 0;
    model_base = 10'h2A5; model_idx = 10'd0; model_delay = 20;
    res_ready = 1'b0; cont_mode = 1'b0;
    pulse_start();
    n_checks++;
    if (busy !== 1'b1) $display("FAIL single_busy: got %b, required 1", busy);
    else n_pass++;
    while (sar_clks === 1'b1 && hi < 300) begin
      hi++;
      @(negedge clk);
    end
    n_checks++;
    if (hi != 4) $display("FAIL single_clks_high: got %0d cycles, required 4", hi);
    else n_pass++;
    wait_clkc_low("single_clkc");
    // CLKC first sampled at the next edge; valid follows 3 edges after that.
    while (res_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat != 4) $display("FAIL single_latency: got %0d negedges, required 4", lat);
    else n_pass++;
    n_checks++;
    if (res_data !== 10'h2A5) $display("FAIL single_data: got %h, required 2a5", res_data);
    else n_pass++;
    n_checks++;
    if (conv_cnt !== 16'd1) $display("FAIL single_cnt: got %0d, required 1", conv_cnt);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL single_idle: got busy %b, required 0", busy);
    else n_pass++;
    res_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b0) $display("FAIL single_accept: got valid %b, required 0", res_valid);
    else n_pass++;
    res_ready = 1'b0;
    $display("test_single_shot done");
  endtask

  task automatic test_back_to_back();
    model_base = 10'h001; model_idx = 10'd0; model_delay = 5;
    res_ready = 1'b0; cont_mode = 1'b1;
    wait_clks(1'b0, "b2b_c1_lo"); wait_clks(1'b1, "b2b_c1_hi");
    n_checks++;
    if (res_data !== 10'h001 || res_valid !== 1'b1) $display("FAIL b2b_c1: got %h/%b, required 001/1", res_data, res_valid);
    else n_pass++;
    n_checks++;
    if (conv_cnt !== 16'd2 || overrun_err !== 1'b0) $display("FAIL b2b_c1_cnt: got %0d/%b, required 2/0", conv_cnt, overrun_err);
    else n_pass++;
    wait_clks(1'b0, "b2b_c2_lo"); wait_clks(1'b1, "b2b_c2_hi");
    n_checks++;
    if (overrun_err !== 1'b1) $display("FAIL b2b_overrun: got %b, required 1", overrun_err);
    else n_pass++;
    n_checks++;
    if (res_data !== 10'h001 || conv_cnt !== 16'd2) $display("FAIL b2b_c2_hold: got %h/%0d, required 001/2", res_data, conv_cnt);
    else n_pass++;
    wait_clks(1'b0, "b2b_c3_lo"); wait_clks(1'b1, "b2b_c3_hi");
    n_checks++;
    if (res_data !== 10'h001 || conv_cnt !== 16'd2) $display("FAIL b2b_c3_hold: got %h/%0d, required 001/2", res_data, conv_cnt);
    else n_pass++;
    res_ready = 1'b1;
    wait_clks(1'b0, "b2b_c4_lo"); wait_clks(1'b1, "b2b_c4_hi");
    n_checks++;
    if (res_data !== 10'h004 || conv_cnt !== 16'd3) $display("FAIL b2b_c4: got %h/%0d, required 004/3", res_data, conv_cnt);
    else n_pass++;
    cont_mode = 1'b0;
    wait_idle("b2b_stop");
    n_checks++;
    if (res_data !== 10'h005 || conv_cnt !== 16'd4) $display("FAIL b2b_last: got %h/%0d, required 005/4", res_data, conv_cnt);
    else n_pass++;
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    n_checks++;
    if (overrun_err !== 1'b0) $display("FAIL b2b_clear: got %b, required 0", overrun_err);
    else n_pass++;
    $display("test_back_to_back done");
  endtask

  task automatic test_simultaneous();
    model_base = 10'h100; model_idx = 10'd0; model_delay = 5;
    res_ready = 1'b0; cont_mode = 1'b0;
    pulse_start();
    wait_idle("simul_first");
    n_checks++;
    if (res_data !== 10'h100 || res_valid !== 1'b1) $display("FAIL simul_first: got %h/%b, required 100/1", res_data, res_valid);
    else n_pass++;
    pulse_start();
    wait_clkc_low("simul_clkc");
    // Two synchroniser edges plus the CONVERT exit edge: the 3rd negedge is inside CAPTURE.
    repeat (3) @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (res_data !== 10'h101 || res_valid !== 1'b1) $display("FAIL simul_load: got %h/%b, required 101/1", res_data, res_valid);
    else n_pass++;
    n_checks++;
    if (overrun_err !== 1'b0 || conv_cnt !== 16'd6) $display("FAIL simul_flags: got %b/%0d, required 0/6", overrun_err, conv_cnt);
    else n_pass++;
    res_ready = 1'b0;
    wait_idle("simul_end");
    $display("test_simultaneous done");
  endtask

  task automatic test_timeout();
    int n = 0;
    model_en = 1'b0;
    pulse_start();
    wait_clks(1'b0, "timeout_convert");
    while (timeout_err !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n != 64) $display("FAIL timeout_cycles: got %0d, required 64", n);
    else n_pass++;
    n_checks++;
    if (sar_clks !== 1'b1 || busy !== 1'b0) $display("FAIL timeout_idle: got clks %b busy %b, required 1/0", sar_clks, busy);
    else n_pass++;
    n_checks++;
    if (res_valid !== 1'b1 || res_data !== 10'h101) $display("FAIL timeout_result: got %b/%h, required 1/101", res_valid, res_data);
    else n_pass++;
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    n_checks++;
    if (timeout_err !== 1'b0) $display("FAIL timeout_clear: got %b, required 0", timeout_err);
    else n_pass++;
    model_en = 1'b1;
    $display("test_timeout done");
  endtask

  task automatic test_reset_mid();
    model_base = 10'h155; model_idx = 10'd0; model_delay = 10;
    pulse_start();
    pulse_start();
    wait_clks(1'b0, "rstmid_convert");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({sar_clks, busy, res_valid, timeout_err, overrun_err} !== 5'b10000)
      $display("FAIL rstmid_flags: got %b, required 10000", {sar_clks, busy, res_valid, timeout_err, overrun_err});
    else n_pass++;
    n_checks++;
    if (conv_cnt !== 16'd0) $display("FAIL rstmid_cnt: got %0d, required 0", conv_cnt);
    else n_pass++;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) $display("FAIL rstmid_quiet: got busy %b valid %b, required 0/0", busy, res_valid);
    else n_pass++;
    pulse_start();
    pulse_start();
    wait_idle("rstmid_single");
    repeat (30) @(negedge clk);
    n_checks++;
    if (conv_cnt !== 16'd1 || busy !== 1'b0) $display("FAIL rstmid_one_result: got cnt %0d busy %b, required 1/0", conv_cnt, busy);
    else n_pass++;
    n_checks++;
    if (res_data !== 10'h155) $display("FAIL rstmid_data: got %h, required 155", res_data);
    else n_pass++;
    $display("test_reset_mid done");
  endtask

  task automatic test_wrap();
    model_base = 10'h3FF; model_idx = 10'd0; model_delay = 6;
    res_ready = 1'b1;
    force dut.r_conv_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_conv_cnt;
    @(negedge clk);
    n_checks++;
    if (conv_cnt !== 16'hFFFF) $display("FAIL wrap_preload: got %h, required ffff", conv_cnt);
    else n_pass++;
    pulse_start();
    wait_idle("wrap_conv");
    n_checks++;
    if (conv_cnt !== 16'h0000) $display("FAIL wrap_cnt: got %h, required 0000", conv_cnt);
    else n_pass++;
    n_checks++;
    if (res_data !== 10'h3FF) $display("FAIL wrap_data: got %h, required 3ff", res_data);
    else n_pass++;
    $display("test_wrap done");
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_back_to_back();
    test_simultaneous();
    test_timeout();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
